// File: rtl/acc_cpu_ctrl_if.sv
// Memory and ALU bus between the accumulator CPU control unit (master)
// and its single-port RAM / combinational ALU (slave).
interface acc_cpu_ctrl_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_wdata;
    logic       mem_cs;
    logic       mem_we;
    logic       mem_oe;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_s;

    modport master (
        output mem_addr, mem_wdata, mem_cs, mem_we, mem_oe, alu_a, alu_b, alu_sel,
        input  mem_rdata, alu_s
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_cs, mem_we, mem_oe, alu_a, alu_b, alu_sel,
        output mem_rdata, alu_s
    );
endinterface

// File: rtl/acc_cpu_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU; owns PC, IRA,
// IRB, MBR and AC and drives the synchronous RAM and the ALU operand registers.
module acc_cpu_ctrl (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    acc_cpu_ctrl_if.master        bus,
    output logic [7:0]            pc,
    output logic [7:0]            ac,
    output logic                  halted,
    output logic                  instr_done
);
    typedef enum logic [3:0] {
        S_IDLE, S_F1A, S_F1D, S_F2A, S_F2D, S_DEC, S_MA,
        S_MD, S_EX, S_WB, S_SW, S_PCW, S_EXEC, S_HALT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_CLEAR = 4'hA;
    localparam logic [3:0] OP_JUMPI = 4'hB;
    localparam logic [3:0] OP_JNS   = 4'hC;
    localparam logic [3:0] OP_NOT   = 4'hD;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d, ac_q, ac_d, ira_q, ira_d, irb_q, irb_d, mbr_q, mbr_d;
    logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0] alu_sel_q, alu_sel_d;
    logic [3:0] op;
    logic       skip_take;
    logic       unused_ira_bits;

    assign op              = ira_q[7:4];
    assign unused_ira_bits = ^ira_q[3:2];

    assign pc          = pc_q;
    assign ac          = ac_q;
    assign bus.alu_a   = alu_a_q;
    assign bus.alu_b   = alu_b_q;
    assign bus.alu_sel = alu_sel_q;

    // Skip condition treats AC as signed two's complement.
    always_comb begin
        case (ira_q[1:0])
            2'b00:   skip_take = ac_q[7];
            2'b01:   skip_take = (ac_q == 8'h00);
            2'b10:   skip_take = !ac_q[7] && (ac_q != 8'h00);
            default: skip_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= 8'h00;
            ac_q      <= 8'h00;
            ira_q     <= 8'h00;
            irb_q     <= 8'h00;
            mbr_q     <= 8'h00;
            alu_a_q   <= 8'h00;
            alu_b_q   <= 8'h00;
            alu_sel_q <= 4'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ac_q      <= ac_d;
            ira_q     <= ira_d;
            irb_q     <= irb_d;
            mbr_q     <= mbr_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ac_d          = ac_q;
        ira_d         = ira_q;
        irb_d         = irb_q;
        mbr_d         = mbr_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        bus.mem_addr  = 8'h00;
        bus.mem_wdata = 8'h00;
        bus.mem_cs    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_oe    = 1'b0;
        halted        = 1'b0;
        instr_done    = 1'b0;

        case (state_q)
            S_IDLE: if (start) state_d = S_F1A;
            S_F1A, S_F2A: begin
                bus.mem_addr = pc_q;
                bus.mem_cs   = 1'b1;
                bus.mem_oe   = 1'b1;
                state_d      = (state_q == S_F1A) ? S_F1D : S_F2D;
            end
            S_F1D: begin
                ira_d   = bus.mem_rdata;
                pc_d    = pc_q + 8'd1;
                state_d = S_F2A;
            end
            S_F2D: begin
                irb_d   = bus.mem_rdata;
                pc_d    = pc_q + 8'd1;
                state_d = S_DEC;
            end
            S_DEC: begin
                case (op)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_JUMPI: state_d = S_MA;
                    OP_STORE, OP_JNS: state_d = S_SW;
                    OP_NOT:           state_d = S_EX;
                    OP_HALT: begin
                        state_d    = S_HALT;
                        instr_done = 1'b1;
                    end
                    default:          state_d = S_EXEC;
                endcase
            end
            S_MA: begin
                bus.mem_addr = irb_q;
                bus.mem_cs   = 1'b1;
                bus.mem_oe   = 1'b1;
                state_d      = S_MD;
            end
            S_MD: begin
                mbr_d = bus.mem_rdata;
                if (op == OP_JUMPI)     state_d = S_PCW;
                else if (op == OP_LOAD) state_d = S_WB;
                else                    state_d = S_EX;
            end
            // ALU mode codes for add/sub/and/or coincide with their opcodes.
            S_EX: begin
                alu_a_d   = ac_q;
                alu_b_d   = mbr_q;
                alu_sel_d = (op == OP_NOT) ? 4'hF : op;
                state_d   = S_WB;
            end
            S_WB: begin
                ac_d       = (op == OP_LOAD) ? mbr_q : bus.alu_s;
                instr_done = 1'b1;
                state_d    = S_F1A;
            end
            S_SW: begin
                bus.mem_addr  = irb_q;
                bus.mem_wdata = (op == OP_JNS) ? pc_q : ac_q;
                bus.mem_cs    = 1'b1;
                bus.mem_we    = 1'b1;
                if (op == OP_JNS) begin
                    state_d = S_PCW;
                end else begin
                    instr_done = 1'b1;
                    state_d    = S_F1A;
                end
            end
            S_PCW: begin
                pc_d       = (op == OP_JNS) ? irb_q + 8'd1 : mbr_q;
                instr_done = 1'b1;
                state_d    = S_F1A;
            end
            S_EXEC: begin
                case (op)
                    OP_SKIP:  if (skip_take) pc_d = pc_q + 8'd2;
                    OP_JUMP:  pc_d = irb_q;
                    OP_CLEAR: ac_d = 8'h00;
                    default:  ;
                endcase
                instr_done = 1'b1;
                state_d    = S_F1A;
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Bench for acc_cpu_ctrl: behavioural RAM and ALU around the DUT, and an
// instruction-level reference model whose per-instruction results feed a scoreboard.
module tb_acc_cpu_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] pc, ac;
    logic       halted, instr_done;

    logic       ld_en, clr_en;
    logic [7:0] ld_addr, ld_data;
    logic [7:0] ram [256];
    logic [7:0] sm  [256];

    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] ac;
        int         cycles;
        bit         halt;
    } exp_t;

    exp_t exp_q[$];

    acc_cpu_ctrl_if bus_if ();

    acc_cpu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus_if),
        .pc         (pc),
        .ac         (ac),
        .halted     (halted),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous read, data valid the cycle after the address.
    always @(posedge clk) begin
        if (clr_en) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (bus_if.mem_cs && bus_if.mem_we) begin
            ram[bus_if.mem_addr] <= bus_if.mem_wdata;
        end
        if (bus_if.mem_cs && bus_if.mem_oe) bus_if.mem_rdata <= ram[bus_if.mem_addr];
    end

    always_comb begin
        case (bus_if.alu_sel)
            4'h3:    bus_if.alu_s = bus_if.alu_a + bus_if.alu_b;
            4'h4:    bus_if.alu_s = bus_if.alu_a - bus_if.alu_b;
            4'h5:    bus_if.alu_s = bus_if.alu_a & bus_if.alu_b;
            4'h6:    bus_if.alu_s = bus_if.alu_a | bus_if.alu_b;
            4'hF:    bus_if.alu_s = ~bus_if.alu_a;
            default: bus_if.alu_s = 8'h00;
        endcase
    end

    always @(negedge clk) begin
        if (bus_if.mem_we === 1'b1) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus_if.mem_addr;
            wr_data <= bus_if.mem_wdata;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        sm[a]   = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic put_prog(input logic [7:0] base, input int n, input logic [63:0] prog);
        for (int i = 0; i < n; i++) put(base + 8'(i), prog[8*(n-1-i) +: 8]);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) sm[i] = 8'h00;
        clr_en = 1'b1;
        @(posedge clk);
        #1 clr_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_pc", pc, 0);
        check_output("rst_ac", ac, 0);
        check_output("rst_addr_wdata", {bus_if.mem_addr, bus_if.mem_wdata}, 0);
        check_output("rst_alu", {bus_if.alu_a, bus_if.alu_b, bus_if.alu_sel}, 0);
        check_output("rst_ctrl", {bus_if.mem_cs, bus_if.mem_we, bus_if.mem_oe, halted, instr_done}, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Instruction-level reference: one scoreboard entry per executed instruction.
    task automatic model_run();
        logic [7:0] mpc, mac, ira, irb, nxt, opnd;
        bit         stop, take;
        exp_t       e;
        mpc  = 8'h00;
        mac  = 8'h00;
        stop = 1'b0;
        for (int k = 0; k < 24 && !stop; k++) begin
            ira      = sm[mpc];
            nxt      = mpc + 8'd1;
            irb      = sm[nxt];
            mpc      = mpc + 8'd2;
            opnd     = sm[irb];
            e.cycles = 6;
            case (ira[7:4])
                4'h1: begin mac = opnd;        e.cycles = 8; end
                4'h2: sm[irb] = mac;
                4'h3: begin mac = mac + opnd;  e.cycles = 9; end
                4'h4: begin mac = mac - opnd;  e.cycles = 9; end
                4'h5: begin mac = mac & opnd;  e.cycles = 9; end
                4'h6: begin mac = mac | opnd;  e.cycles = 9; end
                4'hD: begin mac = ~mac;        e.cycles = 7; end
                4'h7: begin stop = 1'b1;       e.cycles = 5; end
                4'h8: begin
                    case (ira[1:0])
                        2'b00:   take = $signed(mac) < 0;
                        2'b01:   take = mac == 8'h00;
                        2'b10:   take = $signed(mac) > 0;
                        default: take = 1'b0;
                    endcase
                    if (take) mpc = mpc + 8'd2;
                end
                4'h9: mpc = irb;
                4'hA: mac = 8'h00;
                4'hB: begin mpc = opnd; e.cycles = 8; end
                4'hC: begin sm[irb] = mpc; mpc = irb + 8'd1; e.cycles = 7; end
                default: ;
            endcase
            e.pc   = mpc;
            e.ac   = mac;
            e.halt = stop;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_program(input string name);
        exp_t e;
        int   cyc;
        bit   done;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_output({name, "_f1a_addr"}, bus_if.mem_addr, 8'h00);
        check_output({name, "_f1a_ctrl"}, {bus_if.mem_cs, bus_if.mem_oe, bus_if.mem_we}, 3'b110);
        while (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            cyc  = 0;
            done = 1'b0;
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (instr_done) done = 1'b1;
            end
            check_output({name, "_done_seen"}, done, 1);
            if (!done) begin
                exp_q.delete();
                break;
            end
            check_output({name, "_cycles"}, cyc, e.cycles);
            if (e.halt) begin
                @(negedge clk);
                check_output({name, "_halted"}, halted, 1);
            end else begin
                @(posedge clk);
                #1;
            end
            check_output({name, "_pc"}, pc, e.pc);
            check_output({name, "_ac"}, ac, e.ac);
        end
    endtask

    initial begin
        int  w0;
        bit  seen;
        rst_n   = 1'b0;
        start   = 1'b0;
        ld_en   = 1'b0;
        clr_en  = 1'b0;
        ld_addr = 8'h00;
        ld_data = 8'h00;
        $display("[TB] start");

        // load / add / halt, then halt stickiness
        do_reset();
        clear_mem();
        put_prog(8'h00, 6, 64'h0000_1010_3011_7000);
        put(8'h10, 8'h05);
        put(8'h11, 8'hFB);
        model_run();
        release_reset();
        run_program("ldadd");
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check_output("sticky_halted", halted, 1);
        check_output("sticky_pc", pc, 8'h06);
        check_output("sticky_cs", bus_if.mem_cs, 0);

        // store
        do_reset();
        clear_mem();
        put_prog(8'h00, 6, 64'h0000_1010_2030_7000);
        put(8'h10, 8'h05);
        model_run();
        release_reset();
        w0 = wr_cnt;
        run_program("store");
        check_output("store_wr_count", wr_cnt - w0, 1);
        check_output("store_wr_addr", wr_addr, 8'h30);
        check_output("store_wr_data", wr_data, 8'h05);
        check_output("store_readback", ram[8'h30], 8'h05);

        // skip conditions
        do_reset();
        clear_mem();
        put_prog(8'h00, 8, 64'h8100_A000_1010_8000);
        put_prog(8'h08, 8, 64'hA000_8200_8300_7000);
        put(8'h10, 8'h80);
        model_run();
        release_reset();
        run_program("skip");

        // jns / jumpi with add and not
        do_reset();
        clear_mem();
        put_prog(8'h00, 8, 64'h1010_3011_0000_D000);
        put_prog(8'h08, 4, 64'h0000_0000_C040_7000);
        put_prog(8'h41, 2, 64'h0000_0000_0000_B040);
        put(8'h10, 8'h07);
        put(8'h11, 8'h02);
        model_run();
        release_reset();
        run_program("jns");
        check_output("jns_ret_addr", ram[8'h40], 8'h0A);

        // sub / and / or, skip on negative, jump
        do_reset();
        clear_mem();
        put_prog(8'h00, 8, 64'h1010_4011_5012_6013);
        put_prog(8'h08, 6, 64'h0000_8000_A000_9020);
        put_prog(8'h20, 2, 64'h0000_0000_0000_7000);
        put(8'h10, 8'h9C);
        put(8'h11, 8'h1E);
        put(8'h12, 8'hF3);
        put(8'h13, 8'h81);
        model_run();
        release_reset();
        run_program("logic");

        // PC wrap through 0xFF
        do_reset();
        clear_mem();
        put_prog(8'h00, 7, 64'h0010_1090_FF00_7000);
        put(8'h10, 8'h55);
        put(8'h90, 8'h77);
        put(8'hFF, 8'hA0);
        model_run();
        release_reset();
        run_program("wrap");

        // reset asserted in the middle of a write
        do_reset();
        clear_mem();
        put_prog(8'h00, 4, 64'h0000_0000_2030_7000);
        release_reset();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.mem_we === 1'b1) seen = 1'b1;
        end
        check_output("midrst_we_seen", seen, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("midrst_we", bus_if.mem_we, 0);
        check_output("midrst_cs", bus_if.mem_cs, 0);
        check_output("midrst_pc", pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_output("midrst_idle", {bus_if.mem_cs, halted, pc}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
